// File: rtl/block_pack_fifo.sv
// Word-to-block packing FIFO: packs WORD_W words MSB-first into BLOCK_W blocks, DEPTH slots deep.
// Define BLOCK_PACK_FIFO_FLUSH_EN to add a flush input that zero-pads and commits a partial block.
module block_pack_fifo #(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned BLOCK_W = 128,
    parameter int unsigned DEPTH   = 2,
    localparam int unsigned WPB    = BLOCK_W / WORD_W,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
    localparam int unsigned WC_W   = (WPB > 2) ? $clog2(WPB) : 1
) (
    input  logic               clk,
    input  logic               n_rst,
`ifdef BLOCK_PACK_FIFO_FLUSH_EN
    input  logic               flush,
`endif
    input  logic               write_en,
    input  logic [WORD_W-1:0]  data_in,
    input  logic               read_en,
    output logic [BLOCK_W-1:0] data_out,
    output logic               data_valid,
    output logic               fifo_empty,
    output logic               fifo_full,
    output logic [CNT_W-1:0]   block_count,
    output logic [WC_W-1:0]    word_count,
    output logic               overflow,
    output logic               underflow
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WC_W:0] WPB_C = (WC_W + 1)'(WPB);

    logic [BLOCK_W-1:0] slot_q [DEPTH];
    logic [BLOCK_W-1:0] slot_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WC_W-1:0]    wc_q, wc_d;
    logic [BLOCK_W-1:0] dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    logic               empty, full;
    logic               wr_acc, rd_acc, commit, flush_req;
    logic [WC_W:0]      wc_post;
    int unsigned        wr_base;

`ifdef BLOCK_PACK_FIFO_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    always_comb begin
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        wc_d     = wc_q;

        wr_acc  = write_en && !full;
        rd_acc  = read_en && !empty;
        wc_post = {1'b0, wc_q} + {{WC_W{1'b0}}, wr_acc};
        wr_base = (WPB - 1 - int'(wc_q)) * WORD_W;

        // Clearing the slot on the first word makes a later flush a plain commit.
        if (wr_acc) begin
            if (wc_q == '0) begin
                slot_d[wr_ptr_q] = '0;
            end
            slot_d[wr_ptr_q][wr_base +: WORD_W] = data_in;
        end

        commit = !full && ((wc_post == WPB_C) || (flush_req && (wc_post != '0)));
        if (commit) begin
            wc_d     = '0;
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wc_d = wc_post[WC_W-1:0];
        end

        if (rd_acc) begin
            dout_d   = slot_q[rd_ptr_q];
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        valid_d = rd_acc;

        count_d = count_q + CNT_W'(commit) - CNT_W'(rd_acc);
        ovf_d   = ovf_q | (write_en & full);
        unf_d   = unf_q | (read_en & empty);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wc_q     <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wc_q     <= wc_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign data_out    = dout_q;
    assign data_valid  = valid_q;
    assign fifo_empty  = empty;
    assign fifo_full   = full;
    assign block_count = count_q;
    assign word_count  = wc_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: tb/tb_block_pack_fifo.sv
// Randomized self-checking bench for block_pack_fifo against a queue-based reference model.
// Flush scenarios are exercised only when BLOCK_PACK_FIFO_FLUSH_EN is defined.
module tb_block_pack_fifo;

    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 128;
    localparam int DEPTH   = 2;
    localparam int WPB     = BLOCK_W / WORD_W;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int WC_W    = (WPB > 2) ? $clog2(WPB) : 1;
`ifdef BLOCK_PACK_FIFO_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               n_rst;
    logic               flush;
    logic               write_en;
    logic [WORD_W-1:0]  data_in;
    logic               read_en;
    logic [BLOCK_W-1:0] data_out;
    logic               data_valid;
    logic               fifo_empty;
    logic               fifo_full;
    logic [CNT_W-1:0]   block_count;
    logic [WC_W-1:0]    word_count;
    logic               overflow;
    logic               underflow;

    block_pack_fifo #(
        .WORD_W (WORD_W),
        .BLOCK_W(BLOCK_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
`ifdef BLOCK_PACK_FIFO_FLUSH_EN
        .flush      (flush),
`endif
        .write_en   (write_en),
        .data_in    (data_in),
        .read_en    (read_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .block_count(block_count),
        .word_count (word_count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a queue of complete blocks plus a queue of pending words.
    logic [BLOCK_W-1:0] mq[$];
    logic [WORD_W-1:0]  part[$];
    logic [BLOCK_W-1:0] m_dout;
    logic               m_valid, m_ovf, m_unf;

    task automatic check(input string tag, input logic [BLOCK_W-1:0] obs,
                         input logic [BLOCK_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        part.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic model_step(input logic we, input logic [WORD_W-1:0] d, input logic re,
                              input logic fl);
        logic [BLOCK_W-1:0] blk;
        bit full_now, empty_now;
        full_now  = (mq.size() == DEPTH);
        empty_now = (mq.size() == 0);
        m_valid   = 1'b0;
        if (re) begin
            if (!empty_now) begin
                m_dout  = mq.pop_front();
                m_valid = 1'b1;
            end else begin
                m_unf = 1'b1;
            end
        end
        if (we) begin
            if (!full_now) part.push_back(d);
            else m_ovf = 1'b1;
        end
        if (!full_now && (part.size() == WPB || (fl && FLUSH_EN && part.size() > 0))) begin
            blk = '0;
            for (int i = 0; i < part.size(); i++) begin
                blk[BLOCK_W-1-i*WORD_W -: WORD_W] = part[i];
            end
            mq.push_back(blk);
            part.delete();
        end
    endtask

    task automatic compare_all();
        check("data_out", data_out, m_dout);
        check("data_valid", BLOCK_W'(data_valid), BLOCK_W'(m_valid));
        check("fifo_empty", BLOCK_W'(fifo_empty), BLOCK_W'(mq.size() == 0));
        check("fifo_full", BLOCK_W'(fifo_full), BLOCK_W'(mq.size() == DEPTH));
        check("block_count", BLOCK_W'(block_count), BLOCK_W'(mq.size()));
        check("word_count", BLOCK_W'(word_count), BLOCK_W'(part.size()));
        check("overflow", BLOCK_W'(overflow), BLOCK_W'(m_ovf));
        check("underflow", BLOCK_W'(underflow), BLOCK_W'(m_unf));
    endtask

    task automatic cycle(input logic we, input logic [WORD_W-1:0] d, input logic re,
                         input logic fl);
        @(negedge clk);
        write_en = we;
        data_in  = d;
        read_en  = re;
        flush    = fl;
        model_step(we, d, re, fl);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        flush    = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    logic [WORD_W-1:0] words_a [8];
    logic [WORD_W-1:0] words_t2 [4];

    initial begin
        n_rst    = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        flush    = 1'b0;
        data_in  = '0;
        model_reset();
        #12;
        compare_all();
        check("reset_data_out", data_out, '0);
        @(negedge clk);
        n_rst = 1'b1;

        // Single block round trip.
        words_t2 = '{32'hdeb0f813, 32'h41f3503a, 32'h7cd01e2b, 32'hc7cdd556};
        for (int i = 0; i < 4; i++) cycle(1'b1, words_t2[i], 1'b0, 1'b0);
        check("t2_count", BLOCK_W'(block_count), BLOCK_W'(1));
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("t2_data", data_out, 128'hdeb0f81341f3503a7cd01e2bc7cdd556);
        check("t2_valid", BLOCK_W'(data_valid), BLOCK_W'(1));
        idle();
        check("t2_valid_drop", BLOCK_W'(data_valid), BLOCK_W'(0));

        // Fill to full, overflow, drain.
        words_a = '{32'h7D8AE0F7, 32'hCFA0A6CB, 32'h09FB5D05, 32'hA8EC586D,
                    32'hE6FEBF30, 32'h133874EB, 32'hCB49226C, 32'hD36D0D4F};
        for (int i = 0; i < 8; i++) cycle(1'b1, words_a[i], 1'b0, 1'b0);
        check("t3_full", BLOCK_W'(fifo_full), BLOCK_W'(1));
        cycle(1'b1, 32'h12345678, 1'b0, 1'b1);
        check("t3_overflow", BLOCK_W'(overflow), BLOCK_W'(1));
        check("t3_wc_after_drop", BLOCK_W'(word_count), BLOCK_W'(0));
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("t3_blk_a", data_out, 128'h7D8AE0F7CFA0A6CB09FB5D05A8EC586D);
        check("t3_not_full", BLOCK_W'(fifo_full), BLOCK_W'(0));
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("t3_blk_b", data_out, 128'hE6FEBF30133874EBCB49226CD36D0D4F);
        check("t3_empty", BLOCK_W'(fifo_empty), BLOCK_W'(1));

        // Read on empty, then async reset mid-assembly.
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("t4_underflow", BLOCK_W'(underflow), BLOCK_W'(1));
        check("t4_hold", data_out, 128'hE6FEBF30133874EBCB49226CD36D0D4F);
        check("t4_no_valid", BLOCK_W'(data_valid), BLOCK_W'(0));
        cycle(1'b1, 32'h1, 1'b0, 1'b0);
        cycle(1'b1, 32'h2, 1'b0, 1'b0);
        write_en = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        check("t4_rst_wc", BLOCK_W'(word_count), BLOCK_W'(0));
        check("t4_rst_unf", BLOCK_W'(underflow), BLOCK_W'(0));
        check("t4_rst_dout", data_out, '0);
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;

        // Simultaneous read and block-completing write.
        for (int i = 0; i < 7; i++) cycle(1'b1, words_a[i], 1'b0, 1'b0);
        cycle(1'b1, words_a[7], 1'b1, 1'b0);
        check("t5_count", BLOCK_W'(block_count), BLOCK_W'(1));
        check("t5_old_blk", data_out, 128'h7D8AE0F7CFA0A6CB09FB5D05A8EC586D);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("t5_new_blk", data_out, 128'hE6FEBF30133874EBCB49226CD36D0D4F);

`ifdef BLOCK_PACK_FIFO_FLUSH_EN
        cycle(1'b1, 32'hE6FEBF30, 1'b0, 1'b0);
        cycle(1'b1, 32'h133874EB, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("t6_count", BLOCK_W'(block_count), BLOCK_W'(1));
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("t6_flushed", data_out, 128'hE6FEBF30133874EB0000000000000000);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("t6_flush_noop", BLOCK_W'(block_count), BLOCK_W'(0));
`endif

        // Randomized traffic with a mid-run reset.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            cycle(1'($urandom_range(0, 99) < 60), $urandom, 1'($urandom_range(0, 99) < 25),
                  1'($urandom_range(0, 99) < 8));
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/block_pack_fifo.md
Name: block_pack_fifo

Overview:
- Parametrised word-to-block packing FIFO. It generalises the fixed 32-bit-in / 128-bit-out RX FIFO that feeds the AES top level.
- Accepts WORD_W-bit words, assembles them MSB-first into BLOCK_W-bit blocks, and buffers up to DEPTH complete blocks.
- The AES block consumes data_out as dataPacketIn.
- Adds multi-block depth, occupancy reporting, sticky overflow/underflow flags and an optional partial-block flush.

Parameters:
WORD_W, 32, input word width in bits
BLOCK_W, 128, output block width in bits; must be an integer multiple of WORD_W with WPB = BLOCK_W/WORD_W >= 2
DEPTH, 2, number of complete-block slots (>= 1; need not be a power of two)

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
write_en  in  1  push data_in this cycle
data_in  in  WORD_W  word to push
read_en  in  1  pop one complete block
data_out  out  BLOCK_W  last popped block, registered
data_valid  out  1  one-cycle pulse when data_out has just been updated by a pop
fifo_empty  out  1  no complete block stored
fifo_full  out  1  all DEPTH slots hold complete blocks
block_count  out  $clog2(DEPTH+1)  number of complete blocks stored
word_count  out  max(1,$clog2(WPB))  words held in the block under assembly
overflow  out  1  sticky: a write was dropped
underflow  out  1  sticky: a read hit an empty FIFO

Behaviour:
- Single clock domain: clk. Asynchronous reset: n_rst low clears everything immediately.
- Reset values:
  - data_out=0, data_valid=0, fifo_empty=1, fifo_full=0
  - block_count=0, word_count=0, overflow=0, underflow=0
  - read/write pointers=0
- Reset asserted mid-assembly discards the partial block and all stored blocks.
- Storage: DEPTH block slots plus a tail assembly position in slot[wr_ptr]. Pointers advance modulo DEPTH, wrapping from DEPTH-1 to 0.
- Write: accepted when write_en=1 and fifo_full=0.
  - Word i of a block (i = word_count) lands in bits [BLOCK_W-1-i*WORD_W -: WORD_W], so the first word is the MSBs.
  - word_count increments on each accepted word.
  - On the WPB-th word the block commits: word_count returns to 0, wr_ptr advances, and block_count increments on the next edge.
- Write while fifo_full=1: the word is dropped, overflow is set, and all other state is unchanged.
- Read: accepted when read_en=1 and fifo_empty=0.
  - On the next edge data_out <= slot[rd_ptr], rd_ptr advances, block_count decrements, and data_valid=1 for exactly that cycle.
  - Read latency is 1 cycle.
- Read while fifo_empty=1: underflow is set; data_out holds and data_valid stays 0.
- Simultaneous accepted read and block-completing write: block_count is unchanged and both pointers advance.
  - This can only occur when block_count < DEPTH, because writes are blocked when full.
  - The slot freed by a read is not writable until the following cycle.
- fifo_empty = (block_count==0). fifo_full = (block_count==DEPTH). Both are derived from registered state, with no combinational path from read_en or write_en.
- A partial block (word_count>0) is never readable and does not affect fifo_empty.
- overflow and underflow clear only on reset.

Optional Feature:
- Macro: BLOCK_PACK_FIFO_FLUSH_EN.
- Enabled: adds input port flush (1 bit).
  - When flush=1, fifo_full=0 and the post-write word_count > 0, the remaining words of the assembly block are zero-filled and the block commits that cycle; word_count goes to 0.
  - A write in the same cycle is stored first, then padding is applied. If that write completes the block, flush is a no-op.
  - Flush with word_count==0 is a no-op.
  - Flush while fifo_full=1 is ignored.
- Disabled: no flush port; partial blocks wait for the remaining words.

Test Plan:
1. Reset -> fifo_empty=1, fifo_full=0, block_count=0, word_count=0, data_out=0, overflow=underflow=0.
2. Write deb0f813, 41f3503a, 7cd01e2b, c7cdd556 -> block_count=1, fifo_empty=0. Then read -> next cycle data_out=deb0f81341f3503a7cd01e2bc7cdd556 and data_valid pulses once.
3. DEPTH=2: write 8 words (block A = 7D8AE0F7 CFA0A6CB 09FB5D05 A8EC586D, block B = E6FEBF30 133874EB CB49226C D36D0D4F) -> fifo_full=1. A 9th word is dropped and overflow=1. Read -> data_out=A and fifo_full=0. Read -> data_out=B and fifo_empty=1.
4. Read on empty -> underflow=1, data_valid=0, data_out unchanged. Pull n_rst low after 2 words -> word_count=0 and underflow=0 immediately.
5. block_count=1 with 3 words of a partial block: assert read_en together with the 4th write -> block_count stays 1, data_out = the old block, and the new block is readable next.
6. (FLUSH_EN) Write E6FEBF30, 133874EB, then flush -> block_count=1. Read returns E6FEBF30133874EB0000000000000000.
